mul_sequencer: RTL and testbench

Multi-cycle controller and accumulator for the RISC-V M-extension multiply operations (MUL, MULH, MULHSU, MULHU). It accepts one request from the execute stage over a valid/ready handshake and captures and sign-extends the operands. It then sequences K partial-product iterations through a Booth step sub-module and returns the selected XLEN-bit result over a second valid/ready handshake. Stall generation for the core is derived from its busy/ready outputs.

---
 rtl/mul_sequencer_pkg.sv | 38 +++
 rtl/mul_sequencer_booth_step.sv | 47 ++++
 rtl/mul_sequencer.sv | 125 ++++++++++++
 tb/tb_mul_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared types and operand-signedness helpers for the multi-cycle multiplier.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic rs1_signed(input mul_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // rs2 is treated as signed for MULH only
  function automatic logic rs2_signed(input mul_op_t op);
    return (op == MULH);
  endfunction

  // Radix-4 Booth digit for the bit triple {y[2i+1], y[2i], y[2i-1]}
  function automatic int booth_digit(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return 1;
      3'b011:         return 2;
      3'b100:         return -2;
      3'b101, 3'b110: return -1;
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/mul_sequencer_booth_step.sv
// One partial-product step: a times a C-bit multiplier chunk, shifted into
// place by index*C. The chunk is unsigned except for the most significant
// one (LAST), which carries the sign of the extended multiplier.
module booth_step
  import mul_sequencer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int C    = 9,
  parameter int J    = 2,
  parameter bit LAST = 1'b0
) (
  input  logic [XLEN:0]     a,
  input  logic [C-1:0]      chunk,
  input  logic [J-1:0]      index,
  output logic [2*XLEN+1:0] product
);

  localparam int AW = 2 * XLEN + 2;
  // Chunk plus one extension bit, rounded up to an even Booth width
  localparam int W  = ((C + 2) / 2) * 2;

  logic [C:0]    chunk_x;
  logic [W:0]    y;
  logic [AW-1:0] a_x;
  logic [AW-1:0] sum;

  assign chunk_x = LAST ? {chunk[C-1], chunk} : {1'b0, chunk};
  assign y       = {W'($signed(chunk_x)), 1'b0};
  assign a_x     = AW'($signed(a));

  // Accumulate the recoded radix-4 digits of the chunk times a
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < W / 2; i++) begin
      case (booth_digit(y[2*i +: 3]))
        1:       sum = sum + (a_x << (2 * i));
        2:       sum = sum + (a_x << (2 * i + 1));
        -1:      sum = sum - (a_x << (2 * i));
        -2:      sum = sum - (a_x << (2 * i + 1));
        default: sum = sum;
      endcase
    end
  end

  assign product = sum << (32'(index) * C);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle RV32M multiply sequencer: accepts one request, runs K
// partial-product iterations into a wide accumulator, then presents the
// selected half of the product until the consumer takes it.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int K    = 4,
  localparam int J    = (K > 2) ? $clog2(K) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  mul_op_t         i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic [J-1:0]    o_index
);

  localparam int C  = (XLEN + K) / K;   // ceil((XLEN+1)/K)
  localparam int KC = K * C;
  localparam int AW = 2 * XLEN + 2;

  if ((K < 1) || (K > XLEN + 1)) begin : g_bad_k
    $error("mul_sequencer: K must be in 1..XLEN+1");
  end

  mul_state_t    state_q, state_d;
  mul_op_t       op_q;
  logic [XLEN:0] a_q, b_q;
  logic [AW-1:0] acc_q;
  logic [J-1:0]  index_q;
  logic          last;
  logic [KC-1:0] b_ext;
  logic [C-1:0]  chunk;
  logic [AW-1:0] pp_mid, pp_last, pp;
  logic          unused_acc_hi;

  assign last  = (index_q == J'(K - 1));
  assign b_ext = KC'($signed(b_q));
  assign chunk = b_ext[index_q * C +: C];

  booth_step #(.XLEN(XLEN), .C(C), .J(J), .LAST(1'b0)) u_step_mid (
    .a      (a_q),
    .chunk  (chunk),
    .index  (index_q),
    .product(pp_mid)
  );

  booth_step #(.XLEN(XLEN), .C(C), .J(J), .LAST(1'b1)) u_step_last (
    .a      (a_q),
    .chunk  (chunk),
    .index  (index_q),
    .product(pp_last)
  );

  assign pp = last ? pp_last : pp_mid;

  // Next-state: flush forces IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = BUSY;
      BUSY:    if (last)    state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // State, operand capture, iteration counter and accumulator
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_q    <= MUL;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_flush) begin
        index_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_valid) begin
              op_q    <= i_op;
              a_q     <= {rs1_signed(i_op) & i_rs1[XLEN-1], i_rs1};
              b_q     <= {rs2_signed(i_op) & i_rs2[XLEN-1], i_rs2};
              acc_q   <= '0;
              index_q <= '0;
            end
          end
          BUSY: begin
            acc_q   <= acc_q + pp;
            index_q <= last ? '0 : index_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Result select, driven only while the result is being offered
  always_comb begin
    o_result = '0;
    if (state_q == DONE)
      o_result = (op_q == MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_index = index_q;

  assign unused_acc_hi = ^acc_q[AW-1:2*XLEN];

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed vectors and corner
// sequences on a K=4 instance, random sweep across K in {1,3,4,33}.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready;
  mul_op_t     i_op;
  logic [31:0] i_rs1, i_rs2;

  logic        rdy_w [4];
  logic        vld_w [4];
  logic        bsy_w [4];
  logic [31:0] res_w [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  function automatic int k_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 33;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int KG = k_of(g);
    localparam int JG = (KG > 2) ? $clog2(KG) : 1;
    logic [JG-1:0] idx;
    mul_sequencer #(.XLEN(32), .K(KG)) u_dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_flush),
      .i_valid (i_valid),
      .o_ready (rdy_w[g]),
      .i_op    (i_op),
      .i_rs1   (i_rs1),
      .i_rs2   (i_rs2),
      .o_valid (vld_w[g]),
      .i_ready (i_ready),
      .o_result(res_w[g]),
      .o_busy  (bsy_w[g]),
      .o_index (idx)
    );
  end

  // Reference: full 64-bit product of the extended operands
  function automatic logic [31:0] ref_mul(input mul_op_t op, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = (op == MULH || op == MULHSU) ? longint'($signed(x)) : longint'({32'b0, x});
    sy = (op == MULH) ? longint'($signed(y)) : longint'({32'b0, y});
    p  = sx * sy;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    mul_op_t     op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},  32'(rdy_w[2]), 1);
    check({tag, "_valid"},  32'(vld_w[2]), 0);
    check({tag, "_busy"},   32'(bsy_w[2]), 0);
    check({tag, "_index"},  32'(g_dut[2].idx), 0);
    check({tag, "_result"}, res_w[2], 0);
  endtask

  task automatic start_op(input mul_op_t op, input logic [31:0] x, input logic [31:0] y);
    i_op    = op;
    i_rs1   = x;
    i_rs2   = y;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  // Called in the first cycle after accept; cyc counts cycles since accept
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!vld_w[2] && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic ack();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    vec_t vecs [10];
    int   lat;
    logic seen;
    logic [31:0] held;

    vecs = '{
      '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
      '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001},
      '{MUL,    32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001},
      '{MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF},
      '{MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000}
    };

    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_op = MUL; i_rs1 = '0; i_rs2 = '0;
    tick();
    tick();
    check_reset("reset");
    i_rst = 1'b0;
    tick();

    // Table-driven vectors on the K=4 instance
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].rs1, vecs[i].rs2);
      wait_valid(lat);
      check($sformatf("tbl%0d_result", i), res_w[2], vecs[i].exp);
      check($sformatf("tbl%0d_latency", i), lat, 5);
      ack();
    end

    // Index walk and exact valid timing
    start_op(MUL, 32'd7, 32'hFFFF_FFFD);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("walk_index%0d", c), 32'(g_dut[2].idx), c);
      check($sformatf("walk_novalid%0d", c), 32'(vld_w[2]), 0);
      tick();
    end
    check("walk_valid", 32'(vld_w[2]), 1);
    check("walk_result", res_w[2], 32'hFFFF_FFEB);
    ack();
    check("walk_ready_after", 32'(rdy_w[2]), 1);

    // Backpressure with a pending request held on i_valid
    start_op(MULH, 32'h8000_0000, 32'h8000_0000);
    wait_valid(lat);
    held = res_w[2];
    i_op = MULHU; i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'hFFFF_FFFF; i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(vld_w[2]), 1);
      check("bp_result", res_w[2], held);
      check("bp_ready", 32'(rdy_w[2]), 0);
      tick();
    end
    check("bp_result_value", held, 32'h4000_0000);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("bp_idle_ready", 32'(rdy_w[2]), 1);
    check("bp_idle_valid", 32'(vld_w[2]), 0);
    tick();
    i_valid = 1'b0;
    check("bp_accepted_busy", 32'(bsy_w[2]), 1);
    check("bp_accepted_index", 32'(g_dut[2].idx), 0);
    wait_valid(lat);
    check("bp_pending_latency", lat, 5);
    check("bp_pending_result", res_w[2], 32'hFFFF_FFFE);
    ack();

    // Flush at index 2
    start_op(MUL, 32'd5, 32'd6);
    tick();
    tick();
    check("flush_at_index", 32'(g_dut[2].idx), 2);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush_ready", 32'(rdy_w[2]), 1);
    check("flush_busy", 32'(bsy_w[2]), 0);
    check("flush_index", 32'(g_dut[2].idx), 0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen |= vld_w[2];
      tick();
    end
    check("flush_no_valid", 32'(seen), 0);
    start_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    check("post_flush_result", res_w[2], 32'hFFFF_FFFE);
    ack();

    // Reset mid-BUSY and in DONE
    start_op(MULH, 32'd3, 32'd4);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_reset("rst_busy");
    start_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    check("rst_done_valid_before", 32'(vld_w[2]), 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_reset("rst_done");

    // Flush and request in the same IDLE cycle
    i_op = MUL; i_rs1 = 32'd9; i_rs2 = 32'd9;
    i_valid = 1'b1; i_flush = 1'b1;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_accept_busy", 32'(bsy_w[2]), 0);
    check("flush_accept_ready", 32'(rdy_w[2]), 1);
    tick();
    check("flush_accept_busy_later", 32'(bsy_w[2]), 0);

    // Random sweep across all instances
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      mul_op_t     op;
      logic [31:0] x, y, exp;
      logic        got [4];
      logic        all_got;
      op  = mul_op_t'(2'($urandom_range(0, 3)));
      x   = pick();
      y   = pick();
      exp = ref_mul(op, x, y);
      got = '{1'b0, 1'b0, 1'b0, 1'b0};
      start_op(op, x, y);
      for (int cyc = 1; cyc <= 80; cyc++) begin
        all_got = 1'b1;
        for (int g = 0; g < 4; g++) begin
          if (!got[g] && vld_w[g]) begin
            got[g] = 1'b1;
            check($sformatf("sweep_result_k%0d", k_of(g)), res_w[g], exp);
            check($sformatf("sweep_latency_k%0d", k_of(g)), cyc, k_of(g) + 1);
          end
          all_got &= got[g];
        end
        if (all_got) break;
        tick();
      end
      for (int g = 0; g < 4; g++)
        check($sformatf("sweep_completed_k%0d", k_of(g)), 32'(got[g]), 1);
      tick();
    end
    i_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
